// File: rtl/rate_sequencer_ctrl.sv
// rtl/rate_sequencer_ctrl.sv - run/step tick-rate controller with round-robin speed arbiter
//
// Purpose:
//   Counts down the divider period for the selected speed and raises Enable for
//   one cycle at each period boundary. Two requesters share the speed setting
//   through a round-robin arbiter feeding a one-entry pending register. A new
//   speed is applied at once while idle, and otherwise only at a boundary.
//
// Ports:
//   ClockIn       in   1  system clock, rising edge
//   Reset         in   1  asynchronous active-low reset
//   Start         in   1  pulse, IDLE -> RUN
//   Stop          in   1  pulse, RUN/STEP -> IDLE
//   Step          in   1  pulse, IDLE -> STEP (one Enable after one period)
//   ReqValid      in   2  per-requester speed-change request
//   ReqSpeed0     in   2  speed offered by requester 0
//   ReqSpeed1     in   2  speed offered by requester 1
//   ReqReady      out  2  per-requester accept (one-hot or zero)
//   ActiveSpeed   out  2  speed currently in force
//   PendingValid  out  1  an accepted speed waits to be applied
//   Enable        out  1  one-cycle tick per period
//   Busy          out  1  state is RUN or STEP

module rate_sequencer_ctrl #(
  parameter int CLOCK_FREQUENCY = 4
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Step,
  input  logic [1:0] ReqValid,
  input  logic [1:0] ReqSpeed0,
  input  logic [1:0] ReqSpeed1,
  output logic [1:0] ReqReady,
  output logic [1:0] ActiveSpeed,
  output logic       PendingValid,
  output logic       Enable,
  output logic       Busy
);

  localparam int CW = $clog2(4 * CLOCK_FREQUENCY) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] count;
  logic [1:0]    active_speed;
  logic [1:0]    pend_speed;
  logic          pend_valid;
  logic          rr_last;      // requester granted most recently
  logic          at_zero;
  logic          tick;
  logic          load;
  logic          apply;
  logic [1:0]    grant;
  logic [1:0]    boundary_speed;

  // Reload value P(s)-1, evaluated at full counter width.
  function automatic logic [CW-1:0] reload(input logic [1:0] s);
    case (s)
      2'd0:    reload = '0;
      2'd1:    reload = CW'(CLOCK_FREQUENCY - 1);
      2'd2:    reload = CW'(2 * CLOCK_FREQUENCY - 1);
      default: reload = CW'(4 * CLOCK_FREQUENCY - 1);
    endcase
  endfunction

  assign at_zero = (count == '0);
  assign tick    = (state != S_IDLE) && at_zero;

  // Pending speed is applied immediately in IDLE, or at a boundary while counting.
  assign apply          = pend_valid && ((state == S_IDLE) || tick);
  assign boundary_speed = apply ? pend_speed : active_speed;

  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    Enable     = tick;
    Busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        // Stop dominates; Start dominates Step.
        if (!Stop) begin
          if (Start) begin
            state_next = S_RUN;
            load       = 1'b1;
          end else if (Step) begin
            state_next = S_STEP;
            load       = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (Stop) state_next = S_IDLE;
      end
      S_STEP: begin
        if (Stop || at_zero) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Grants only while the pending slot is empty and out of reset; on contention
  // the requester that was not granted last wins.
  always_comb begin
    grant = 2'b00;
    if (Reset && !pend_valid) begin
      if (ReqValid == 2'b11) begin
        grant = rr_last ? 2'b01 : 2'b10;
      end else begin
        grant = ReqValid;
      end
    end
  end

  assign ReqReady     = grant;
  assign ActiveSpeed  = active_speed;
  assign PendingValid = pend_valid;

  // Counter holds in IDLE and reloads at zero, so it never wraps.
  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (load) begin
      count <= reload(active_speed);
    end else if (state != S_IDLE) begin
      count <= at_zero ? reload(boundary_speed) : count - 1'b1;
    end
  end

  // A grant needs an empty slot and an apply needs a full one, so they never coincide.
  always_ff @(posedge ClockIn or negedge Reset) begin
    if (!Reset) begin
      active_speed <= 2'd1;
      pend_speed   <= 2'd0;
      pend_valid   <= 1'b0;
      rr_last      <= 1'b1;
    end else begin
      if (apply) begin
        active_speed <= pend_speed;
        pend_valid   <= 1'b0;
      end
      if (grant != 2'b00) begin
        pend_valid <= 1'b1;
        pend_speed <= grant[1] ? ReqSpeed1 : ReqSpeed0;
        rr_last    <= grant[1];
      end
    end
  end

endmodule

// File: tb/tb_rate_sequencer_ctrl.sv
// tb/tb_rate_sequencer_ctrl.sv - scoreboard bench for rate_sequencer_ctrl

module tb_rate_sequencer_ctrl;

  localparam int F = 4;

  logic       clk;
  logic       Reset;
  logic       Start;
  logic       Stop;
  logic       Step;
  logic [1:0] ReqValid;
  logic [1:0] ReqSpeed0;
  logic [1:0] ReqSpeed1;
  logic [1:0] ReqReady;
  logic [1:0] ActiveSpeed;
  logic       PendingValid;
  logic       Enable;
  logic       Busy;

  rate_sequencer_ctrl #(.CLOCK_FREQUENCY(F)) dut (
    .ClockIn      (clk),
    .Reset        (Reset),
    .Start        (Start),
    .Stop         (Stop),
    .Step         (Step),
    .ReqValid     (ReqValid),
    .ReqSpeed0    (ReqSpeed0),
    .ReqSpeed1    (ReqSpeed1),
    .ReqReady     (ReqReady),
    .ActiveSpeed  (ActiveSpeed),
    .PendingValid (PendingValid),
    .Enable       (Enable),
    .Busy         (Busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Scoreboard queues: per-cycle status {en, ready[1:0], active[1:0], pend, busy}
  // and the absolute cycle numbers at which Enable is expected.
  logic [6:0] stat_q[$];
  int         tick_q[$];

  // Reference model, expressed in absolute time: mode 0=idle 1=run 2=step,
  // m_next = cycle of the next boundary.
  int m_mode;
  int m_next;
  int m_act;
  bit m_pv;
  int m_ps;
  int m_last;

  // Requester side stimulus.
  logic [1:0] rv;
  logic [1:0] rs[2];

  logic [6:0] mon_got;
  logic [6:0] mon_exp;
  int         mon_tick;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int got, int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, expv);
    end
  endfunction

  function automatic int per(int s);
    case (s)
      0:       return 1;
      1:       return F;
      2:       return 2 * F;
      default: return 4 * F;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_next = 0;
    m_act  = 1;
    m_pv   = 0;
    m_ps   = 0;
    m_last = 1;
  endtask

  // Drive one cycle of inputs, predict this cycle's outputs, advance the model.
  task automatic cycle_body(input bit st, input bit sp, input bit stp);
    bit         en;
    int         g;
    int         old_act;
    logic [1:0] rdy;
    Start     = st;
    Stop      = sp;
    Step      = stp;
    ReqValid  = rv;
    ReqSpeed0 = rs[0];
    ReqSpeed1 = rs[1];

    en = (m_mode != 0) && (cyc == m_next);
    g  = -1;
    if (!m_pv) begin
      if (rv == 2'b11)  g = (m_last == 1) ? 0 : 1;
      else if (rv[0])   g = 0;
      else if (rv[1])   g = 1;
    end
    rdy = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
    stat_q.push_back({en, rdy, 2'(m_act), m_pv, (m_mode != 0)});
    if (en) tick_q.push_back(cyc);

    old_act = m_act;
    if (m_mode == 0) begin
      if (m_pv) begin
        m_act = m_ps;
        m_pv  = 0;
      end
      if (!sp) begin
        if (st) begin
          m_mode = 1;
          m_next = cyc + per(old_act);
        end else if (stp) begin
          m_mode = 2;
          m_next = cyc + per(old_act);
        end
      end
    end else begin
      if (en) begin
        if (m_pv) begin
          m_act = m_ps;
          m_pv  = 0;
        end
        m_next = cyc + per(m_act);
        if (m_mode == 2) m_mode = 0;
      end
      if (sp) m_mode = 0;
    end
    if (g >= 0) begin
      m_pv   = 1;
      m_ps   = int'(rs[g]);
      m_last = g;
      rv[g]  = 1'b0;
    end
  endtask

  task automatic do_cycle(input bit st, input bit sp, input bit stp);
    @(posedge clk);
    #1;
    cycle_body(st, sp, stp);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset between edges with requesters asserting; outputs must clear at once.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    ReqValid = 2'b11;
    Reset    = 1'b0;
    #1;
    chk("rst_enable", int'(Enable), 0);
    chk("rst_pending", int'(PendingValid), 0);
    chk("rst_speed", int'(ActiveSpeed), 1);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_ready", int'(ReqReady), 0);
    @(posedge clk);
    #1;
    Reset = 1'b1;
    model_reset();
    rv = 2'b00;
    cycle_body(1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (Reset) begin
      mon_got = {Enable, ReqReady, ActiveSpeed, PendingValid, Busy};
      if (stat_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL status_underflow cycle %0d: got %b expected none", cyc, mon_got);
      end else begin
        mon_exp = stat_q.pop_front();
        chk("status{en,rdy,spd,pend,busy}", int'(mon_got), int'(mon_exp));
      end
      if (Enable) begin
        if (tick_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL enable_unexpected cycle %0d: got 1 expected 0", cyc);
        end else begin
          mon_tick = tick_q.pop_front();
          chk("enable_cycle", cyc, mon_tick);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset     = 1'b0;
    Start     = 1'b0;
    Stop      = 1'b0;
    Step      = 1'b0;
    ReqValid  = 2'b00;
    ReqSpeed0 = 2'b00;
    ReqSpeed1 = 2'b00;
    rv        = 2'b00;
    rs[0]     = 2'd0;
    rs[1]     = 2'd0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("init_enable", int'(Enable), 0);
    chk("init_busy", int'(Busy), 0);
    chk("init_pending", int'(PendingValid), 0);
    chk("init_speed", int'(ActiveSpeed), 1);
    chk("init_ready", int'(ReqReady), 0);
    Reset = 1'b1;
    cycle_body(1'b0, 1'b0, 1'b0);

    // Run at the reset speed: ticks every F cycles.
    do_cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(14);

    // Contended speed change: requester 0 (speed 3) then requester 1 (speed 0).
    rv    = 2'b11;
    rs[0] = 2'd3;
    rs[1] = 2'd0;
    idle_cycles(45);
    do_cycle(1'b0, 1'b1, 1'b0);

    // Step at speed 2 from IDLE.
    rv    = 2'b01;
    rs[0] = 2'd2;
    idle_cycles(3);
    do_cycle(1'b0, 1'b0, 1'b1);
    idle_cycles(12);

    // Stop coincident with a RUN boundary.
    do_cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40 && m_mode != 0; i++) begin
      @(posedge clk);
      #1;
      cycle_body(1'b0, (m_mode == 1) && (m_next == cyc), 1'b0);
    end
    idle_cycles(12);

    // Start+Step enters RUN; Start+Stop stays IDLE.
    do_cycle(1'b1, 1'b0, 1'b1);
    idle_cycles(10);
    do_cycle(1'b0, 1'b1, 1'b0);
    do_cycle(1'b1, 1'b1, 1'b0);
    idle_cycles(10);

    // Reset mid-period while a speed is pending.
    rv    = 2'b01;
    rs[0] = 2'd3;
    idle_cycles(3);
    do_cycle(1'b1, 1'b0, 1'b0);
    idle_cycles(20);
    rv    = 2'b01;
    rs[0] = 2'd1;
    idle_cycles(2);
    mid_reset();
    idle_cycles(12);

    // Randomised traffic with an occasional asynchronous reset.
    for (int i = 0; i < 1500; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!rv[r] && $urandom_range(0, 7) == 0) begin
          rv[r] = 1'b1;
          rs[r] = 2'($urandom_range(0, 3));
        end
      end
      if (i == 700) begin
        mid_reset();
      end else begin
        do_cycle($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 19) == 0);
      end
    end
    idle_cycles(3);

    @(negedge clk);
    #1;
    chk("status_queue_drained", stat_q.size(), 0);
    chk("tick_queue_drained", tick_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
